// File: rtl/dma_arbiter.sv
// dma_arbiter: shares one DMA read port between NUM_REQ burst requesters.
//
// Requesters are granted round-robin, starting from the index after the last one
// served. The granted request's address and count are latched onto the DMA port,
// DMA_read is held until DMA_ready (or a timeout), then a one-cycle done pulse is
// returned to the served requester.
//
// Build option: define DMA_ARB_FIXED_PRIORITY_EN to replace round-robin with fixed
// priority (lowest requesting index always wins).
//
// Ports:
//   clk, rst (sync, active low), clk_en (holds all state when low)
//   req / req_address / req_count   packed per-requester burst requests
//   grant / done                    one-hot owner, one-cycle completion pulse
//   DMA_read / DMA_address / DMA_count / DMA_ready   DMA read port
//   busy                            arbiter not idle
//   timeout_err                     sticky, set when a transfer is force-released
module dma_arbiter #(
  parameter int unsigned NUM_REQ             = 2,
  parameter int unsigned MEM_ADDRESS_WIDTH   = 16,
  parameter int unsigned LAYER_ADDRESS_WIDTH = 7,
  parameter int unsigned TIMEOUT_CYCLES      = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clk_en,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0]   req_address,
  input  logic [NUM_REQ*LAYER_ADDRESS_WIDTH-1:0] req_count,
  output logic [NUM_REQ-1:0]                     grant,
  output logic [NUM_REQ-1:0]                     done,
  output logic                                   DMA_read,
  output logic [MEM_ADDRESS_WIDTH-1:0]           DMA_address,
  output logic [LAYER_ADDRESS_WIDTH-1:0]         DMA_count,
  input  logic                                   DMA_ready,
  output logic                                   busy,
  output logic                                   timeout_err
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e                           state_q, state_d;
  logic [NUM_REQ-1:0]               grant_q, grant_d;
  logic [NUM_REQ-1:0]               done_q, done_d;
  logic                             read_q, read_d;
  logic [MEM_ADDRESS_WIDTH-1:0]     addr_q, addr_d;
  logic [LAYER_ADDRESS_WIDTH-1:0]   count_q, count_d;
  logic                             err_q, err_d;
  logic [IdxW-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]                  gidx_q, gidx_d;
  logic [CntW-1:0]                  cnt_q, cnt_d;

  logic [MEM_ADDRESS_WIDTH-1:0]     addr_arr  [NUM_REQ];
  logic [LAYER_ADDRESS_WIDTH-1:0]   count_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_address[i*MEM_ADDRESS_WIDTH +: MEM_ADDRESS_WIDTH];
    assign count_arr[i] = req_count[i*LAYER_ADDRESS_WIDTH +: LAYER_ADDRESS_WIDTH];
  end

  // Requester selection
  logic            sel_valid;
  logic [IdxW-1:0] sel_idx;
  logic [IdxW-1:0] cand;

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
`ifdef DMA_ARB_FIXED_PRIORITY_EN
    // Scan high to low so the lowest requesting index is assigned last and wins.
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = IdxW'(k - 1);
      if (req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
`else
    // Scan from the farthest offset back to rr_ptr+1 so the nearest requester after
    // the last one served is assigned last and wins.
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    read_d   = read_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          grant_d = NUM_REQ'(1) << sel_idx;
          gidx_d  = sel_idx;
          addr_d  = addr_arr[sel_idx];
          count_d = count_arr[sel_idx];
          // A zero-length burst needs no DMA access; finish it straight away.
          if (count_arr[sel_idx] != '0) begin
            read_d  = 1'b1;
            cnt_d   = '0;
            state_d = StWait;
          end else begin
            state_d = StDone;
          end
        end
      end
      StWait: begin
        if (DMA_ready) begin
          read_d  = 1'b0;
          state_d = StDone;
        end else if (TIMEOUT_CYCLES != 0 && 32'(cnt_q) + 32'd1 == TIMEOUT_CYCLES) begin
          // Force release; the done pulse still goes out so the requester can move on.
          err_d   = 1'b1;
          read_d  = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        done_d   = grant_q;
        grant_d  = '0;
        rr_ptr_d = gidx_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      done_q   <= '0;
      read_q   <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      rr_ptr_q <= IdxW'(NUM_REQ - 1);
      gidx_q   <= '0;
      cnt_q    <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign DMA_read    = read_q;
  assign DMA_address = addr_q;
  assign DMA_count   = count_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Testbench for dma_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a transaction-level reference model.
module tb_dma_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 7;
  localparam int unsigned TO = 8;

  logic            clk = 1'b0;
  logic            rst, clk_en, DMA_ready;
  logic [N-1:0]    req, grant, done;
  logic [N*AW-1:0] req_address;
  logic [N*CW-1:0] req_count;
  logic            DMA_read, busy, timeout_err;
  logic [AW-1:0]   DMA_address;
  logic [CW-1:0]   DMA_count;

  always #5 clk = ~clk;

  dma_arbiter #(
    .NUM_REQ(N), .MEM_ADDRESS_WIDTH(AW), .LAYER_ADDRESS_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .req_address(req_address),
    .req_count(req_count), .grant(grant), .done(done), .DMA_read(DMA_read),
    .DMA_address(DMA_address), .DMA_count(DMA_count), .DMA_ready(DMA_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit bit_of(logic [N-1:0] v, int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  // Reference model: who owns the port, whether the burst is outstanding or closing,
  // and which requester was served last.
  int          m_owner;
  int          m_last;
  int unsigned m_waited;
  bit          m_xfer, m_closing, m_err;
  logic [AW-1:0] m_addr;
  logic [CW-1:0] m_cnt;
  logic [N-1:0]  m_done;

  task automatic model_step();
    int pick;
    if (!rst) begin
      m_owner = -1; m_last = N - 1; m_waited = 0; m_xfer = 0; m_closing = 0;
      m_err = 0; m_addr = '0; m_cnt = '0; m_done = '0;
    end else if (clk_en) begin
      m_done = '0;
      if (m_closing) begin
        m_done = N'(1) << m_owner;
        m_last = m_owner;
        m_owner = -1;
        m_closing = 0;
      end else if (m_xfer) begin
        if (DMA_ready) begin
          m_xfer = 0; m_closing = 1;
        end else begin
          m_waited++;
          if (TO != 0 && m_waited == TO) begin
            m_err = 1; m_xfer = 0; m_closing = 1;
          end
        end
      end else begin
        pick = -1;
`ifdef DMA_ARB_FIXED_PRIORITY_EN
        for (int c = N - 1; c >= 0; c--) if (bit_of(req, c)) pick = c;
`else
        for (int off = 1; off <= N; off++) begin
          int c;
          c = (m_last + off) % N;
          if (pick < 0 && bit_of(req, c)) pick = c;
        end
`endif
        if (pick >= 0) begin
          m_owner = pick;
          m_addr  = req_address[pick*AW +: AW];
          m_cnt   = req_count[pick*CW +: CW];
          if (m_cnt != '0) begin
            m_xfer = 1; m_waited = 0;
          end else begin
            m_closing = 1;
          end
        end
      end
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".grant"}, 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check({tag, ".read"}, 32'(DMA_read), 32'(m_xfer));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    check({tag, ".err"}, 32'(timeout_err), 32'(m_err));
    check({tag, ".addr"}, 32'(DMA_address), 32'(m_addr));
    check({tag, ".count"}, 32'(DMA_count), 32'(m_cnt));
  endtask

  // Inputs are stable here; model and DUT both consume them at the coming edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst_n; logic en; logic [N-1:0] req; logic rdy;
    logic [N-1:0] grant; logic [N-1:0] done; logic read; logic busy;
    logic [AW-1:0] addr; logic [CW-1:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic [N-1:0] q, logic y, logic [N-1:0] g,
                              logic [N-1:0] d, logic rd, logic b, logic [AW-1:0] a,
                              logic [CW-1:0] c);
    vec_t v;
    v.rst_n = r; v.en = e; v.req = q; v.rdy = y; v.grant = g; v.done = d;
    v.read = rd; v.busy = b; v.addr = a; v.cnt = c;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin : main
    int seen, hi_cnt, got_done;
    int idx_q[$];
    logic [AW-1:0] adr_q[$];
    logic [N-1:0] prev_g;
    rst = 1'b0; clk_en = 1'b1; req = '0; DMA_ready = 1'b0;
    req_address = '0; req_count = '0;
    req_address[0*AW +: AW] = 16'h0000; req_count[0*CW +: CW] = 7'd121;
    req_address[1*AW +: AW] = 16'h2F7C; req_count[1*CW +: CW] = 7'd0;
    req_address[2*AW +: AW] = 16'h1234; req_count[2*CW +: CW] = 7'd5;

    //             rst en  req    rdy  grant  done  rd b  addr      cnt
    tbl[0]  = mk(0, 1, 3'b011, 0, 3'b000, 3'b000, 0, 0, 16'h0000, 7'd0);
    tbl[1]  = mk(0, 1, 3'b011, 1, 3'b000, 3'b000, 0, 0, 16'h0000, 7'd0);
    tbl[2]  = mk(1, 1, 3'b011, 0, 3'b001, 3'b000, 1, 1, 16'h0000, 7'd121);
    tbl[3]  = mk(1, 1, 3'b011, 0, 3'b001, 3'b000, 1, 1, 16'h0000, 7'd121);
    tbl[4]  = mk(1, 1, 3'b011, 1, 3'b001, 3'b000, 0, 1, 16'h0000, 7'd121);
    tbl[5]  = mk(1, 1, 3'b011, 0, 3'b000, 3'b001, 0, 0, 16'h0000, 7'd121);
    tbl[6]  = mk(1, 1, 3'b000, 1, 3'b000, 3'b000, 0, 0, 16'h0000, 7'd121);
    tbl[7]  = mk(1, 1, 3'b010, 0, 3'b010, 3'b000, 0, 1, 16'h2F7C, 7'd0);
    tbl[8]  = mk(1, 1, 3'b010, 0, 3'b000, 3'b010, 0, 0, 16'h2F7C, 7'd0);
    tbl[9]  = mk(1, 1, 3'b000, 0, 3'b000, 3'b000, 0, 0, 16'h2F7C, 7'd0);
    tbl[10] = mk(1, 1, 3'b100, 0, 3'b100, 3'b000, 1, 1, 16'h1234, 7'd5);
    tbl[11] = mk(1, 0, 3'b000, 1, 3'b100, 3'b000, 1, 1, 16'h1234, 7'd5);
    tbl[12] = mk(1, 0, 3'b000, 1, 3'b100, 3'b000, 1, 1, 16'h1234, 7'd5);
    tbl[13] = mk(1, 0, 3'b000, 1, 3'b100, 3'b000, 1, 1, 16'h1234, 7'd5);
    tbl[14] = mk(1, 1, 3'b000, 1, 3'b100, 3'b000, 0, 1, 16'h1234, 7'd5);
    tbl[15] = mk(1, 0, 3'b000, 0, 3'b100, 3'b000, 0, 1, 16'h1234, 7'd5);
    tbl[16] = mk(1, 1, 3'b000, 0, 3'b000, 3'b100, 0, 0, 16'h1234, 7'd5);
    tbl[17] = mk(1, 0, 3'b000, 0, 3'b000, 3'b100, 0, 0, 16'h1234, 7'd5);
    tbl[18] = mk(1, 1, 3'b000, 0, 3'b000, 3'b000, 0, 0, 16'h1234, 7'd5);

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst_n; clk_en = tbl[i].en; req = tbl[i].req; DMA_ready = tbl[i].rdy;
      tick();
      check($sformatf("t%0d.grant", i), 32'(grant), 32'(tbl[i].grant));
      check($sformatf("t%0d.done", i), 32'(done), 32'(tbl[i].done));
      check($sformatf("t%0d.read", i), 32'(DMA_read), 32'(tbl[i].read));
      check($sformatf("t%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("t%0d.addr", i), 32'(DMA_address), 32'(tbl[i].addr));
      check($sformatf("t%0d.count", i), 32'(DMA_count), 32'(tbl[i].cnt));
      check($sformatf("t%0d.err", i), 32'(timeout_err), 32'd0);
    end

    // Contention: both requesters held high for four transfers.
    clk_en = 1'b1; req = 3'b011; DMA_ready = 1'b1; req_count[1*CW +: CW] = 7'd3;
    prev_g = '0;
    for (int c = 0; c < 40 && idx_q.size() < 4; c++) begin
      tick();
      check_model("cont");
      if (grant != '0 && prev_g == '0) begin
        for (int k = 0; k < N; k++) if (bit_of(grant, k)) idx_q.push_back(k);
        adr_q.push_back(DMA_address);
      end
      prev_g = grant;
    end
    check("cont.transfers", 32'(idx_q.size()), 32'd4);
    for (int k = 0; k < idx_q.size() && k < 4; k++) begin
`ifdef DMA_ARB_FIXED_PRIORITY_EN
      check($sformatf("cont.idx%0d", k), 32'(idx_q[k]), 32'd0);
      check($sformatf("cont.adr%0d", k), 32'(adr_q[k]), 32'h0000);
`else
      check($sformatf("cont.idx%0d", k), 32'(idx_q[k]), 32'(k % 2));
      check($sformatf("cont.adr%0d", k), 32'(adr_q[k]), (k % 2 == 1) ? 32'h2F7C : 32'h0000);
`endif
    end
    req = '0;
    for (int c = 0; c < 6; c++) begin tick(); check_model("drain"); end

    // Timeout: no DMA_ready, read must drop after TO cycles in WAIT.
    req = 3'b001; DMA_ready = 1'b0; hi_cnt = 0; got_done = 0;
    for (int c = 0; c < 30 && got_done == 0; c++) begin
      tick();
      check_model("tmo");
      if (DMA_read) hi_cnt++;
      if (done[0]) begin got_done = 1; req = '0; end
    end
    check("tmo.read_cycles", 32'(hi_cnt), TO);
    check("tmo.done_seen", 32'(got_done), 32'd1);
    check("tmo.err", 32'(timeout_err), 32'd1);
    // The next request is served normally and the error stays set.
    req = 3'b010; DMA_ready = 1'b1; seen = 0;
    for (int c = 0; c < 12 && seen == 0; c++) begin
      tick();
      check_model("post");
      if (done[1]) begin seen = 1; req = '0; end
    end
    check("post.done_seen", 32'(seen), 32'd1);
    check("post.err_sticky", 32'(timeout_err), 32'd1);
    check("post.addr", 32'(DMA_address), 32'h2F7C);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) != 0);
      clk_en    = ($urandom_range(0, 9) < 8);
      DMA_ready = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (bit_of(done, i)) begin
          req = req & ~(N'(1) << i);
        end else if (!bit_of(req, i) && $urandom_range(0, 3) == 0) begin
          req = req | (N'(1) << i);
          req_address[i*AW +: AW] = AW'($urandom);
          req_count[i*CW +: CW] = ($urandom_range(0, 7) == 0) ? '0 : CW'($urandom_range(1, 127));
        end else if (!bit_of(req, i) || m_owner == i) begin
          // Slices not part of a pending request are free to wander.
          req_address[i*AW +: AW] = AW'($urandom);
          req_count[i*CW +: CW] = CW'($urandom);
        end
      end
      tick();
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
